// File: rtl/branch_pattern_table.sv
// branch_pattern_table: pattern history table of 2-bit saturating counters.
// Fetch presents a PC each cycle and gets a registered taken/not-taken
// prediction plus the table index one cycle later. Execute returns that
// index with the resolved outcome to train the counter.
// Optional build macro BPT_GSHARE_EN: XOR a non-speculative global history
// register into the lookup index (gshare). Undefined gives a bimodal table.
module branch_pattern_table #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update_en,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            counters [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_index;
  logic [1:0]            update_next;
  logic [1:0]            lookup_count;

  // Upper PC bits never reach the table index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[PC_WIDTH-1:INDEX_BITS];

`ifdef BPT_GSHARE_EN
  logic [HIST_BITS-1:0]  ghr;
  logic [INDEX_BITS-1:0] ghr_ext;

  // Lookup index: PC bits XOR zero-extended history as it stood before this edge.
  always_comb begin
    ghr_ext                 = '0;
    ghr_ext[HIST_BITS-1:0]  = ghr;
    lookup_index            = fetch_pc[INDEX_BITS-1:0] ^ ghr_ext;
  end

  // History shifts in resolved outcomes only, so it never needs repair.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ghr <= '0;
    end else if (update_en) begin
      ghr <= {ghr[HIST_BITS-2:0], update_taken};
    end
  end
`else
  localparam int unused_hist_bits = HIST_BITS;

  // Bimodal lookup: index straight from the low PC bits.
  always_comb begin
    lookup_index = fetch_pc[INDEX_BITS-1:0];
  end
`endif

  // Saturating next value for the counter being trained this cycle.
  always_comb begin
    update_next = counters[update_index];
    if (update_taken) begin
      if (update_next != 2'b11) begin
        update_next = update_next + 2'd1;
      end
    end else begin
      if (update_next != 2'b00) begin
        update_next = update_next - 2'd1;
      end
    end
  end

  // Counter seen by fetch, with same-cycle training forwarded so a hot branch sees its newest state.
  always_comb begin
    if (update_en && (update_index == lookup_index)) begin
      lookup_count = update_next;
    end else begin
      lookup_count = counters[lookup_index];
    end
  end

  // Counter array: whole table clears to weak-not-taken, one entry written per training event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        counters[i] <= 2'b01;
      end
    end else if (update_en) begin
      counters[update_index] <= update_next;
    end
  end

  // Registered prediction outputs, updated every cycle regardless of fetch_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= fetch_valid;
      pred_taken <= lookup_count[1];
      pred_index <= lookup_index;
    end
  end

endmodule

// File: tb/tb_branch_pattern_table.sv
// tb_branch_pattern_table: scoreboard bench for branch_pattern_table.
// Directed sequences plus random traffic; an array-of-ints model predicts each
// response, a monitor pops and compares whenever pred_valid is high.
module tb_branch_pattern_table;

  localparam int INDEX_BITS = 6;
  localparam int HIST_BITS  = 6;
  localparam int PC_WIDTH   = 32;
  localparam int ENTRIES    = 64;

  logic                  clock;
  logic                  reset;
  logic                  fetch_valid;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  pred_valid;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  update_en;
  logic [INDEX_BITS-1:0] update_index;
  logic                  update_taken;

  int errors = 0;
  int checks = 0;

  // Reference model state: counter values 0..3 and history as an integer.
  int modelCount [ENTRIES];
  int modelHist;

  // Expected {taken, index} for each valid fetch, in issue order.
  logic [6:0] expQ [$];

  branch_pattern_table #(
    .INDEX_BITS(INDEX_BITS),
    .HIST_BITS (HIST_BITS),
    .PC_WIDTH  (PC_WIDTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_index  (pred_index),
    .update_en   (update_en),
    .update_index(update_index),
    .update_taken(update_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) modelCount[i] = 1;
    modelHist = 0;
    expQ.delete();
  endtask

  // Drive one cycle of inputs at the falling edge and record the expected response.
  task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic ue,
                               input logic [5:0] ui, input logic ut);
    int idx;
    @(negedge clock);
    fetch_valid  = fv;
    fetch_pc     = pc;
    update_en    = ue;
    update_index = ui;
    update_taken = ut;
    idx = int'(pc % ENTRIES);
`ifdef BPT_GSHARE_EN
    idx = idx ^ modelHist;
`endif
    if (ue) begin
      if (ut) modelCount[ui] = (modelCount[ui] == 3) ? 3 : modelCount[ui] + 1;
      else    modelCount[ui] = (modelCount[ui] == 0) ? 0 : modelCount[ui] - 1;
      modelHist = (modelHist * 2 + (ut ? 1 : 0)) % ENTRIES;
    end
    if (fv) expQ.push_back({(modelCount[idx] >= 2), 6'(idx)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic sampleAfterEdge();
    @(posedge clock);
    #1;
  endtask

  // Monitor: whenever a valid prediction appears, it must match the oldest expectation.
  initial begin
    logic [6:0] exp;
    forever begin
      @(posedge clock);
      #1;
      if (pred_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected pred_valid", 32'(pred_valid), 32'd0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("sb pred_index", 32'(pred_index), 32'(exp[5:0]));
          checkOutput("sb pred_taken", 32'(pred_taken), 32'(exp[6]));
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    fetch_valid  = 1'b0;
    fetch_pc     = '0;
    update_en    = 1'b0;
    update_index = '0;
    update_taken = 1'b0;
    modelReset();
    #1;
    checkOutput("reset pred_valid", 32'(pred_valid), 32'd0);
    checkOutput("reset pred_taken", 32'(pred_taken), 32'd0);
    checkOutput("reset pred_index", 32'(pred_index), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // First lookup after reset: weak-not-taken entry 5.
    applyStimulus(1'b1, 32'h5, 1'b0, 6'd0, 1'b0);
    sampleAfterEdge();
    checkOutput("first pred_valid", 32'(pred_valid), 32'd1);
    checkOutput("first pred_index", 32'(pred_index), 32'd5);
    checkOutput("first pred_taken", 32'(pred_taken), 32'd0);

    // Three taken trainings of entry 5, then look up pc 0x10 for the index.
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 6'd5, 1'b1);
    applyStimulus(1'b1, 32'h10, 1'b0, 6'd0, 1'b0);
    sampleAfterEdge();
`ifdef BPT_GSHARE_EN
    checkOutput("gshare index", 32'(pred_index), 32'h17);
`else
    checkOutput("bimodal index", 32'(pred_index), 32'h10);
`endif

    // Saturation walk on entry 5 (literal checks meaningful for the bimodal index).
    applyStimulus(1'b1, 32'h5, 1'b0, 6'd0, 1'b0);
    sampleAfterEdge();
`ifndef BPT_GSHARE_EN
    checkOutput("strong taken", 32'(pred_taken), 32'd1);
`endif
    applyStimulus(1'b1, 32'h5, 1'b1, 6'd5, 1'b1);
    sampleAfterEdge();
`ifndef BPT_GSHARE_EN
    checkOutput("sat high", 32'(pred_taken), 32'd1);
`endif
    applyStimulus(1'b0, 32'h0, 1'b1, 6'd5, 1'b0);
    applyStimulus(1'b1, 32'h5, 1'b1, 6'd5, 1'b0);
    sampleAfterEdge();
`ifndef BPT_GSHARE_EN
    checkOutput("two not-taken", 32'(pred_taken), 32'd0);
`endif
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 6'd5, 1'b0);
    applyStimulus(1'b1, 32'h5, 1'b1, 6'd5, 1'b1);
    sampleAfterEdge();
`ifndef BPT_GSHARE_EN
    checkOutput("sat low", 32'(pred_taken), 32'd0);
`endif

    // Same-cycle bypass on entry 9.
    applyStimulus(1'b1, 32'h9, 1'b1, 6'd9, 1'b1);
    sampleAfterEdge();
`ifndef BPT_GSHARE_EN
    checkOutput("bypass taken", 32'(pred_taken), 32'd1);
`endif

    // Train entry 5 strong, then pulse reset between edges with a training in flight.
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 6'd5, 1'b1);
    applyStimulus(1'b1, 32'h5, 1'b0, 6'd0, 1'b0);
    sampleAfterEdge();
    @(negedge clock);
    fetch_valid  = 1'b0;
    update_en    = 1'b1;
    update_index = 6'd5;
    update_taken = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async pred_valid", 32'(pred_valid), 32'd0);
    checkOutput("async pred_taken", 32'(pred_taken), 32'd0);
    checkOutput("async pred_index", 32'(pred_index), 32'd0);
    @(negedge clock);
    update_en = 1'b0;
    reset     = 1'b1;
    applyStimulus(1'b1, 32'h5, 1'b0, 6'd0, 1'b0);
    sampleAfterEdge();
    checkOutput("post-reset taken", 32'(pred_taken), 32'd0);
    checkOutput("post-reset index", 32'(pred_index), 32'd5);

    // Random traffic with clustered indices to force collisions and bypasses.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'($urandom), ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 15)),
                    1'($urandom), 6'($urandom_range(0, 15)), 1'($urandom));
    end
    idle(3);
    sampleAfterEdge();
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_pattern_table.md
Name: branch_pattern_table

Overview:
- Pattern history table of 2-bit saturating counters for the pipeline's branch predictor.
- Fetch stage presents the PC each cycle. The block returns a registered taken/not-taken prediction plus the table index used.
- Execute stage later returns that index with the resolved outcome, and the indexed counter is trained.
- Sits between fetch (consumer of prediction) and execute (producer of outcome). Replaces per-branch instantiation of single counters with one indexed array.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 counters).
- HIST_BITS, 6, global history register width; must be ≤ INDEX_BITS. Used only when the optional feature is enabled.
- PC_WIDTH, 32, fetch/execute PC width; PC is word-addressed, so bit 0 is the first index bit.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset.
- fetch_valid  in  1  fetch_pc is a real fetch this cycle.
- fetch_pc  in  PC_WIDTH  PC being fetched.
- pred_valid  out  1  registered copy of fetch_valid.
- pred_taken  out  1  prediction for the PC presented last cycle.
- pred_index  out  INDEX_BITS  table index used for that prediction; carried down the pipe.
- update_en  in  1  a branch resolved this cycle.
- update_index  in  INDEX_BITS  pred_index that travelled with the branch.
- update_taken  in  1  actual branch outcome.

Behaviour:
- Storage: 2^INDEX_BITS 2-bit counters.
  - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Prediction is the counter MSB.
- Reset (reset=0, asynchronous):
  - All counters are set to 01.
  - GHR is set to 0.
  - pred_valid=0, pred_taken=0, pred_index=0.
  - Outputs hold these values until the first rising clock edge after reset is released.
- Index: idx = fetch_pc[INDEX_BITS-1:0], modified per the optional feature.
- Prediction latency is 1 cycle. At each rising edge:
  - pred_valid <= fetch_valid.
  - pred_index <= idx.
  - pred_taken <= MSB of counter[idx].
- When fetch_valid=0, pred_index and pred_taken still update from fetch_pc. Consumers ignore them because pred_valid=0.
- Update: on a rising edge with update_en=1, counter[update_index] takes its next value:
  - update_taken=1: increment, saturating at 11. 11 stays 11.
  - update_taken=0: decrement, saturating at 00. 00 stays 00.
- update_en=0: no counter changes.
- Simultaneous predict and update to the same index in one cycle:
  - Bypass applies: pred_taken reflects the post-update counter MSB.
  - Example: counter=01, update_taken=1 → pred_taken=1.
- Update and predict to different indices in one cycle are independent. Exactly one counter is written per cycle at most.
- update_index is used verbatim. The block never recomputes it from a PC, so history changes between predict and resolve cannot misdirect training.
- Reset asserted mid-operation clears all state immediately. An update in flight on that edge is discarded.
- Implementation uses a flop array; asynchronous clear of the whole table is required.

Optional Feature:
- Macro: BPT_GSHARE_EN.
- Defined:
  - An HIST_BITS global history register (GHR) exists.
  - idx = fetch_pc[INDEX_BITS-1:0] XOR {zero-extend(GHR)}.
  - On each update_en=1 edge, GHR <= {GHR[HIST_BITS-2:0], update_taken}, i.e. shift left, newest outcome in the LSB.
  - GHR is non-speculative: it is trained only at resolve time.
  - The fetch lookup uses the GHR value before the edge; there is no bypass of the same-cycle GHR shift into idx.
- Undefined: no GHR flops; idx = fetch_pc[INDEX_BITS-1:0] (bimodal table).
- Ports and timing are identical in both builds.

Test Plan:
- Reset, then fetch_valid=1, fetch_pc=0x00000005 → next cycle pred_valid=1, pred_index=5, pred_taken=0.
- 3× update_en=1, update_index=5, update_taken=1, then fetch pc 5 → pred_taken=1. Counter reaches 11; a 4th taken update leaves it at 11.
- From 11, two not-taken updates (counter ends at 01) → pred_taken=0. Four more not-taken updates hold the counter at 00; a single taken update then → pred_taken=0 (counter 01).
- Same-cycle bypass: counter[9]=01, update_index=9 with update_taken=1 and fetch_pc=9 in the same cycle → pred_taken=1 on the next cycle.
- Reset pulsed low mid-stream after training entry 5 to 11 → pred outputs go to 0 without waiting for a clock edge. A subsequent fetch of pc 5 → pred_taken=0.
- BPT_GSHARE_EN (INDEX_BITS=HIST_BITS=6): three taken updates (GHR=000111), then fetch_pc=0x10 → pred_index=0x17. Without the macro, the same stimulus → pred_index=0x10.
